// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared constants, types and CRC7 step function for the SD
//               CMD-line response path.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    // Full response frame length and the prefix covered by CRC7
    localparam int SD_RESP_LEN      = 48;
    localparam int SD_RESP_CRC_BITS = 40;

    // CRC field value used by R3/R4 responses, which carry no real CRC
    localparam logic [6:0] SD_CRC_ALL_ONES = 7'h7F;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        END  = 3'd4
    } resp_tx_state_t;

    // One bit-serial step of CRC7 (x^7 + x^3 + 1), MSB-first input
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic in_bit);
        logic fb;
        fb = in_bit ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc7
// Description : Bit-serial CRC7 accumulator, zero initial value. Clear has
//               priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       enable,
    input  logic       in_bit,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    // Next CRC value: clear wins, otherwise step only when enabled
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'h00;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, in_bit);
        end
    end

    // CRC register
    always_ff @(posedge clock) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_response_sender.sv
`default_nettype none
// ============================================================================
// Module      : sd_response_sender
// Description : Card-side transmitter for 48-bit SD/SDIO responses on the
//               CMD line. Serialises start/dir/index/arg MSB-first, appends
//               CRC7 over the first 40 bits (or all-ones) and the end bit.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_response_sender
    import sd_pkg::*;
#(
    parameter int NCR_CYCLES = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        send_start,
    input  logic [5:0]  resp_index,
    input  logic [31:0] resp_arg,
    input  logic        no_crc,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        done
);

    // Last value of the Ncr counter before the start bit is launched
    localparam logic [6:0] C_NCR_LAST      = 7'(NCR_CYCLES - 1);
    // Index of the last data bit and of the last CRC bit
    localparam logic [5:0] C_LAST_DATA_BIT = 6'(SD_RESP_CRC_BITS - 1);
    localparam logic [5:0] C_LAST_CRC_BIT  = 6'(SD_RESP_LEN - SD_RESP_CRC_BITS - 2);

    resp_tx_state_t state_q, state_d;
    logic [6:0]     ncr_cnt_q, ncr_cnt_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [39:0]    shift_q, shift_d;
    logic [6:0]     crc_sr_q, crc_sr_d;
    logic           no_crc_q, no_crc_d;
    logic           cmd_out_q, cmd_out_d;
    logic           cmd_oe_q, cmd_oe_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           w_accept;
    logic           w_crc_clear;
    logic           w_crc_en;
    logic [6:0]     w_crc;
    logic [6:0]     w_crc_final;

    // CRC accumulates the data bit currently on the wire during DATA
    sd_crc7 u_crc7 (
        .clock  (clock),
        .clear  (w_crc_clear),
        .enable (w_crc_en),
        .in_bit (cmd_out_q),
        .crc    (w_crc)
    );

    assign w_accept    = (state_q == IDLE) && send_start;
    assign w_crc_clear = reset || w_accept;

    // The CRC register has not yet absorbed the final data bit at the
    // DATA->CRC edge, so fold that bit in here before loading the CRC shifter.
    assign w_crc_final = no_crc_q ? SD_CRC_ALL_ONES : crc7_step(w_crc, cmd_out_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ncr_cnt_d = ncr_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        crc_sr_d  = crc_sr_q;
        no_crc_d  = no_crc_q;
        cmd_out_d = cmd_out_q;
        cmd_oe_d  = cmd_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        w_crc_en  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_out_d = 1'b1;
                cmd_oe_d  = 1'b0;
                if (send_start) begin
                    shift_d   = {2'b00, resp_index, resp_arg};
                    no_crc_d  = no_crc;
                    ncr_cnt_d = 7'd0;
                    busy_d    = 1'b1;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (ncr_cnt_q == C_NCR_LAST) begin
                    // Launch the start bit (MSB of the shifter)
                    cmd_out_d = shift_q[39];
                    cmd_oe_d  = 1'b1;
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = 6'd0;
                    state_d   = DATA;
                end else begin
                    ncr_cnt_d = ncr_cnt_q + 7'd1;
                end
            end

            DATA: begin
                w_crc_en = 1'b1;
                if (bit_cnt_q == C_LAST_DATA_BIT) begin
                    cmd_out_d = w_crc_final[6];
                    crc_sr_d  = {w_crc_final[5:0], 1'b0};
                    bit_cnt_d = 6'd0;
                    state_d   = CRC;
                end else begin
                    cmd_out_d = shift_q[39];
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end

            CRC: begin
                if (bit_cnt_q == C_LAST_CRC_BIT) begin
                    cmd_out_d = 1'b1;
                    state_d   = END;
                end else begin
                    cmd_out_d = crc_sr_q[6];
                    crc_sr_d  = {crc_sr_q[5:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end

            END: begin
                cmd_out_d = 1'b1;
                cmd_oe_d  = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                cmd_out_d = 1'b1;
                cmd_oe_d  = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ncr_cnt_q <= 7'd0;
            bit_cnt_q <= 6'd0;
            shift_q   <= 40'd0;
            crc_sr_q  <= 7'd0;
            no_crc_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ncr_cnt_q <= ncr_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            crc_sr_q  <= crc_sr_d;
            no_crc_q  <= no_crc_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sd_cmd_out = cmd_out_q;
    assign sd_cmd_oe  = cmd_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_response_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_response_sender
// Description : Directed self-checking bench for sd_response_sender, with
//               one instance at Ncr=2 and one at Ncr=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_response_sender;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        start [2];
    logic [5:0]  idx   [2];
    logic [31:0] arg   [2];
    logic        ncrc  [2];
    logic        out   [2];
    logic        oe    [2];
    logic        busy  [2];
    logic        done  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_response_sender #(.NCR_CYCLES(2)) u_dut_ncr2 (
        .clock      (clk),
        .reset      (rst[0]),
        .send_start (start[0]),
        .resp_index (idx[0]),
        .resp_arg   (arg[0]),
        .no_crc     (ncrc[0]),
        .sd_cmd_out (out[0]),
        .sd_cmd_oe  (oe[0]),
        .busy       (busy[0]),
        .done       (done[0])
    );

    sd_response_sender #(.NCR_CYCLES(64)) u_dut_ncr64 (
        .clock      (clk),
        .reset      (rst[1]),
        .send_start (start[1]),
        .resp_index (idx[1]),
        .resp_arg   (arg[1]),
        .no_crc     (ncrc[1]),
        .sd_cmd_out (out[1]),
        .sd_cmd_oe  (oe[1]),
        .busy       (busy[1]),
        .done       (done[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue (or continue) a request on instance d and capture the driven frame.
    // inject_at/reset_at: after this many driven bits, pulse a second request
    // or assert reset. chain: raise a new request on the done cycle.
    task automatic run_frame(
        input  int          d,
        input  bit          launch,
        input  logic [5:0]  ix,
        input  logic [31:0] ag,
        input  logic        nc,
        input  int          inject_at,
        input  int          reset_at,
        input  bit          chain,
        input  logic [5:0]  nix,
        input  logic [31:0] nag,
        output logic [47:0] fr,
        output int          idle,
        output int          drv,
        output int          busy_n,
        output int          done_n,
        output logic        last_out,
        output logic        last_busy
    );
        bit finished = 1'b0;
        fr = '0; idle = 0; drv = 0; busy_n = 0; done_n = 0;
        last_out = 1'bx; last_busy = 1'bx;
        if (launch) begin
            @(posedge clk); #1;
            idx[d] = ix; arg[d] = ag; ncrc[d] = nc; start[d] = 1'b1;
        end
        @(posedge clk); #1;
        start[d] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (oe[d]) begin
                fr = {fr[46:0], out[d]};
                drv++;
            end else if (drv == 0) begin
                idle++;
            end
            busy_n += int'(busy[d]);
            done_n += int'(done[d]);
            if (drv > 0 && !oe[d]) begin
                finished  = 1'b1;
                last_out  = out[d];
                last_busy = busy[d];
                break;
            end
            if (oe[d] && drv == inject_at) begin
                idx[d] = 6'h3F; arg[d] = 32'hFFFF_FFFF; ncrc[d] = 1'b1; start[d] = 1'b1;
            end
            if (oe[d] && drv == reset_at) rst[d] = 1'b1;
            @(posedge clk); #1;
            start[d] = 1'b0;
            rst[d]   = 1'b0;
        end
        chk("frame_end_seen", 64'(finished), 64'd1);
        if (chain) begin
            idx[d] = nix; arg[d] = nag; ncrc[d] = 1'b0; start[d] = 1'b1;
        end else begin
            @(posedge clk); #1;
            done_n += int'(done[d]);
        end
    endtask

    logic [47:0] fr;
    int          idle, drv, busy_n, done_n, stray;
    logic        lo, lb;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; idx[k] = '0; arg[k] = '0; ncrc[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'(out[0]), 64'd1);
        chk("rst_oe", 64'(oe[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // CMD17 R1 response
        run_frame(0, 1, 6'h11, 32'h0000_0900, 1'b0, -1, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("r1_frame", 64'(fr), 64'({8'h11, 32'h0000_0900, 7'h33, 1'b1}));
        chk("r1_ncr", 64'(idle), 64'd2);
        chk("r1_drv", 64'(drv), 64'd48);
        chk("r1_busy_cycles", 64'(busy_n), 64'd50);
        chk("r1_done", 64'(done_n), 64'd1);
        chk("r1_busy_after", 64'(lb), 64'd0);
        chk("r1_out_after", 64'(lo), 64'd1);

        // All-zero fields
        run_frame(0, 1, 6'h00, 32'h0, 1'b0, -1, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("zero_frame", 64'(fr), 64'({40'h0, 7'h00, 1'b1}));
        chk("zero_busy_cycles", 64'(busy_n), 64'd50);
        chk("zero_done", 64'(done_n), 64'd1);

        // R3-style response without CRC
        run_frame(0, 1, 6'h3F, 32'h80FF_8000, 1'b1, -1, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("nocrc_frame", 64'(fr), 64'({2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1}));
        chk("nocrc_drv", 64'(drv), 64'd48);

        // Second request mid-frame is ignored
        run_frame(0, 1, 6'h11, 32'h0000_0900, 1'b0, 10, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("inject_frame", 64'(fr), 64'({8'h11, 32'h0000_0900, 7'h33, 1'b1}));
        chk("inject_done", 64'(done_n), 64'd1);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            stray += int'(oe[0]) + int'(busy[0]);
        end
        chk("inject_no_queue", 64'(stray), 64'd0);

        // Reset while bit 20 is on the wire
        run_frame(0, 1, 6'h11, 32'h0000_0900, 1'b0, -1, 21, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("rst_mid_drv", 64'(drv), 64'd21);
        chk("rst_mid_out", 64'(lo), 64'd1);
        chk("rst_mid_busy", 64'(lb), 64'd0);
        chk("rst_mid_no_done", 64'(done_n), 64'd0);

        // Fresh request after reset must start from a cleared CRC
        run_frame(0, 1, 6'h11, 32'h0000_0900, 1'b0, -1, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("post_rst_frame", 64'(fr), 64'({8'h11, 32'h0000_0900, 7'h33, 1'b1}));

        // Ncr=64 instance, back-to-back request on the done cycle
        run_frame(1, 1, 6'h11, 32'h0000_0900, 1'b0, -1, -1, 1, 6'h00, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("ncr64_frame", 64'(fr), 64'({8'h11, 32'h0000_0900, 7'h33, 1'b1}));
        chk("ncr64_idle", 64'(idle), 64'd64);
        chk("ncr64_busy_cycles", 64'(busy_n), 64'd112);
        chk("ncr64_done", 64'(done_n), 64'd1);
        run_frame(1, 0, 6'h00, 32'h0, 1'b0, -1, -1, 0, 6'h0, 32'h0,
                  fr, idle, drv, busy_n, done_n, lo, lb);
        chk("b2b_frame", 64'(fr), 64'({40'h0, 7'h00, 1'b1}));
        chk("b2b_idle", 64'(idle), 64'd64);
        chk("b2b_done", 64'(done_n), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
